// File: rtl/vga_pixel_pipe_if.sv
// Framebuffer write port between an upstream pixel producer and vga_pixel_pipe.
interface vga_pixel_pipe_if #(
  parameter int unsigned AW = 15
);
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          wr_drop;

  modport master (output wr_valid, wr_addr, wr_data, input  wr_ready, wr_drop);
  modport slave  (input  wr_valid, wr_addr, wr_data, output wr_ready, wr_drop);
endinterface

// File: rtl/vga_pixel_pipe.sv
// 160x120 RGB332 framebuffer scanned out 4x upscaled onto 640x480 VGA, with
// sync strobes delayed to match the 2-cycle pixel pipeline.
module vga_pixel_pipe #(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned AW         = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        sync_b_i,
  input  logic        blank_b_i,
  vga_pixel_pipe_if.slave wr,
  output logic        frame_done,
  output logic        hsync,
  output logic        vsync,
  output logic        sync_b,
  output logic        blank_b,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);
  localparam int unsigned FB_W     = H_ACT >> SCALE_LOG2;
  localparam int unsigned FB_H     = V_ACT >> SCALE_LOG2;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;

  logic          act;
  logic [AW-1:0] rd_addr;
  logic          wr_acc;
  logic          wr_in_range;
  logic          wr_en;
  logic [7:0]    rd_data;
  logic [7:0]    fb_mem [FB_DEPTH];

  logic act_d1, hsync_d1, vsync_d1, sync_b_d1, blank_b_d1, frame_end_d1;

  // Active video owns the RAM port; the producer only gets it while blank.
  assign act         = blank_b_i & (x < 10'(H_ACT)) & (y < 10'(V_ACT));
  assign rd_addr     = AW'(y >> SCALE_LOG2) * AW'(FB_W) + AW'(x >> SCALE_LOG2);
  assign wr.wr_ready = ~act & ~reset;
  assign wr_acc      = wr.wr_valid & wr.wr_ready;
  assign wr_in_range = wr.wr_addr < AW'(FB_DEPTH);
  assign wr_en       = wr_acc & wr_in_range;

  // Single-port framebuffer, contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_mem[wr.wr_addr] <= wr.wr_data;
    end else if (act) begin
      rd_data <= fb_mem[rd_addr];
    end
  end

  // Stage 1: strobes travel alongside the RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_d1       <= 1'b0;
      hsync_d1     <= 1'b1;
      vsync_d1     <= 1'b1;
      sync_b_d1    <= 1'b1;
      blank_b_d1   <= 1'b0;
      frame_end_d1 <= 1'b0;
    end else begin
      act_d1       <= act;
      hsync_d1     <= hsync_i;
      vsync_d1     <= vsync_i;
      sync_b_d1    <= sync_b_i;
      blank_b_d1   <= blank_b_i;
      frame_end_d1 <= (x == 10'd0) & (y == 10'(V_ACT));
    end
  end

  // Stage 2: RGB332 to 888 by bit replication, black outside active video.
  always_ff @(posedge clk) begin
    if (reset) begin
      r          <= 8'd0;
      g          <= 8'd0;
      b          <= 8'd0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      sync_b     <= 1'b1;
      blank_b    <= 1'b0;
      frame_done <= 1'b0;
      wr.wr_drop <= 1'b0;
    end else begin
      if (act_d1) begin
        r <= {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
        g <= {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
        b <= {rd_data[1:0], rd_data[1:0], rd_data[1:0], rd_data[1:0]};
      end else begin
        r <= 8'd0;
        g <= 8'd0;
        b <= 8'd0;
      end
      hsync      <= hsync_d1;
      vsync      <= vsync_d1;
      sync_b     <= sync_b_d1;
      blank_b    <= blank_b_d1;
      frame_done <= frame_end_d1;
      wr.wr_drop <= wr_acc & ~wr_in_range;
    end
  end
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Randomized bench for vga_pixel_pipe against a cycle-level reference model of
// the framebuffer, upscaling, colour expansion and strobe delay.
module tb_vga_pixel_pipe;
  localparam int unsigned AW    = 15;
  localparam int unsigned FB_W  = 160;
  localparam int unsigned DEPTH = 19200;

  typedef struct {
    logic [7:0] r, g, b;
    logic       hs, vs, sb, bb, fd;
  } vid_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       hsync_i, vsync_i, sync_b_i, blank_b_i;
  logic       frame_done, hsync, vsync, sync_b, blank_b;
  logic [7:0] r, g, b;

  vga_pixel_pipe_if #(.AW(AW)) wr_bus ();

  vga_pixel_pipe #(.H_ACT(640), .V_ACT(480), .SCALE_LOG2(2), .AW(AW)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .sync_b_i(sync_b_i), .blank_b_i(blank_b_i),
    .wr(wr_bus), .frame_done(frame_done),
    .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
    .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  logic [7:0] fb_model [DEPTH];
  vid_t       idle_v, prev_v, exp_v;
  logic       exp_drop;
  int         n_vec = 0;
  int         n_err = 0;
  int         fd_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic model_act();
    return blank_b_i && (int'(x) < 640) && (int'(y) < 480);
  endfunction

  // Expected output for the present input cycle, two cycles from now.
  function automatic vid_t ref_pixel();
    vid_t v;
    int   d, rc, gc, bc;
    v.r = 8'd0; v.g = 8'd0; v.b = 8'd0;
    if (model_act()) begin
      d  = int'(fb_model[(int'(y) / 4) * FB_W + int'(x) / 4]);
      rc = d / 32;
      gc = (d / 4) % 8;
      bc = d % 4;
      v.r = 8'((rc * 32) + (rc * 4) + (rc / 2));
      v.g = 8'((gc * 32) + (gc * 4) + (gc / 2));
      v.b = 8'(bc * 85);
    end
    v.hs = hsync_i; v.vs = vsync_i; v.sb = sync_b_i; v.bb = blank_b_i;
    v.fd = (x == 10'd0) && (y == 10'd480);
    return v;
  endfunction

  // One clock: check comb ready, advance model at the edge, check registered outputs.
  task automatic step();
    vid_t cur;
    logic acc;
    #1;
    check("wr_ready", 32'(wr_bus.wr_ready), 32'(!model_act() && !reset));
    @(posedge clk);
    cur      = reset ? idle_v : ref_pixel();
    acc      = wr_bus.wr_valid && !model_act() && !reset;
    exp_v    = reset ? idle_v : prev_v;
    prev_v   = cur;
    exp_drop = acc && (int'(wr_bus.wr_addr) >= DEPTH);
    if (acc && int'(wr_bus.wr_addr) < DEPTH) fb_model[wr_bus.wr_addr] = wr_bus.wr_data;
    #1;
    check("r", 32'(r), 32'(exp_v.r));
    check("g", 32'(g), 32'(exp_v.g));
    check("b", 32'(b), 32'(exp_v.b));
    check("hsync", 32'(hsync), 32'(exp_v.hs));
    check("vsync", 32'(vsync), 32'(exp_v.vs));
    check("sync_b", 32'(sync_b), 32'(exp_v.sb));
    check("blank_b", 32'(blank_b), 32'(exp_v.bb));
    check("frame_done", 32'(frame_done), 32'(exp_v.fd));
    check("wr_drop", 32'(wr_drop_obs()), 32'(exp_drop));
    if (frame_done) fd_count++;
    @(negedge clk);
  endtask

  function automatic logic wr_drop_obs();
    return wr_bus.wr_drop;
  endfunction

  // Standard 800x525 640x480@60 strobe generation for a coordinate.
  task automatic set_timing(input int cx, input int cy);
    x         = 10'(cx);
    y         = 10'(cy);
    blank_b_i = (cx < 640) && (cy < 480);
    hsync_i   = !((cx >= 656) && (cx < 752));
    vsync_i   = !((cy >= 490) && (cy < 492));
    sync_b_i  = hsync_i & vsync_i;
  endtask

  task automatic set_write(input logic v, input int a, input int d);
    wr_bus.wr_valid = v;
    wr_bus.wr_addr  = AW'(a);
    wr_bus.wr_data  = 8'(d);
  endtask

  task automatic set_blank_random();
    set_timing($urandom_range(640, 799), $urandom_range(0, 524));
    blank_b_i = 1'b0;
  endtask

  initial begin
    logic [7:0] sv_r, sv_g, sv_b;
    logic       hold;
    idle_v = '{r: 8'd0, g: 8'd0, b: 8'd0, hs: 1'b1, vs: 1'b1, sb: 1'b1, bb: 1'b0, fd: 1'b0};
    prev_v = idle_v;
    fd_count = 0;
    reset = 1'b1;
    set_timing(700, 500);
    set_write(1'b0, 0, 0);
    @(negedge clk);
    repeat (3) step();
    check("reset_ready", 32'(wr_bus.wr_ready), 32'd0);
    check("reset_blank_b", 32'(blank_b), 32'd0);
    reset = 1'b0;
    repeat (2) step();

    // Red at address 0, then scan the 4x4 block it covers.
    set_write(1'b1, 0, 8'hE0); step();
    set_write(1'b0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      set_timing(i % 4, i / 4);
      step();
      if (i >= 2) begin
        check("red_r", 32'(r), 32'hFF);
        check("red_g", 32'(g), 32'h00);
        check("red_b", 32'(b), 32'h00);
      end
    end
    set_blank_random(); step();
    set_write(1'b1, 161, 8'h6D); step();
    set_write(1'b0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      set_timing(4 + i % 4, 4 + i / 4);
      step();
    end
    check("6d_r", 32'(r), 32'h6D);
    check("6d_g", 32'(g), 32'h6D);
    check("6d_b", 32'(b), 32'h55);

    // Fill the whole framebuffer during blanking.
    for (int a = 0; a < DEPTH; a++) begin
      set_blank_random();
      set_write(1'b1, a, $urandom_range(0, 255));
      step();
    end
    set_write(1'b0, 0, 0);
    set_timing(8, 4); step();
    set_timing(9, 4); step();

    // Producer holds a write through active video; it lands on the first blank cycle.
    set_write(1'b1, 500, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      set_timing(80 + i % 4, 12 + i / 4);
      step();
    end
    set_blank_random(); step();
    set_write(1'b0, 0, 0);
    set_timing(80, 12); step();
    set_timing(81, 12); step();
    step();
    check("held_r", 32'(r), 32'h24);
    check("held_g", 32'(g), 32'hFF);
    check("held_b", 32'(b), 32'h00);

    // Out-of-range write is dropped.
    set_blank_random();
    set_write(1'b1, 19200, 8'hAA); step();
    check("oob_drop", 32'(wr_bus.wr_drop), 32'd1);
    set_write(1'b0, 0, 0); step();
    check("oob_drop_end", 32'(wr_bus.wr_drop), 32'd0);

    // Two frame tails through the standard timing: one frame_done each.
    for (int f = 0; f < 2; f++) begin
      fd_count = 0;
      for (int cy = 478; cy < 482; cy++)
        for (int cx = 0; cx < 800; cx++) begin
          set_timing(cx, cy);
          step();
        end
      check("frame_done_count", 32'(fd_count), 32'd1);
    end

    // Random mix of active/blank/out-of-area pixels and stalled writes.
    hold = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    set_blank_random();
        2:       begin set_timing(0, 480); blank_b_i = 1'b0; end
        3:       begin set_timing($urandom_range(640, 799), $urandom_range(0, 524)); blank_b_i = 1'b1; end
        default: set_timing($urandom_range(0, 639), $urandom_range(0, 479));
      endcase
      hsync_i  = 1'($urandom_range(0, 1));
      vsync_i  = 1'($urandom_range(0, 1));
      sync_b_i = 1'($urandom_range(0, 1));
      if (!hold) begin
        if ($urandom_range(0, 2) == 0)
          set_write(1'b1, ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 32767)
                                                      : $urandom_range(0, DEPTH - 1),
                    $urandom_range(0, 255));
        else
          set_write(1'b0, 0, 0);
      end
      hold = wr_bus.wr_valid && model_act();
      step();
    end
    set_write(1'b0, 0, 0);

    // Reset mid-line with a pending write that must not land.
    for (int cx = 200; cx < 400; cx++) begin
      set_timing(cx, 100);
      if (cx >= 300 && cx < 303) begin
        reset = 1'b1;
        set_write(1'b1, 7, 32'(~fb_model[7]));
      end else begin
        reset = 1'b0;
        set_write(1'b0, 0, 0);
      end
      step();
      if (cx == 302) begin
        sv_r = r; sv_g = g; sv_b = b;
        check("rst_rgb", {8'd0, sv_r, sv_g, sv_b}, 32'd0);
        check("rst_sync", {29'd0, hsync, vsync, sync_b}, 32'd7);
        check("rst_blank_b", 32'(blank_b), 32'd0);
      end
    end

    // Full readback confirms every cell, including the ones that must be untouched.
    for (int cy = 0; cy < 120; cy++)
      for (int cx = 0; cx < 160; cx++) begin
        set_timing(cx * 4 + $urandom_range(0, 3), cy * 4 + $urandom_range(0, 3));
        step();
      end
    set_blank_random(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_pixel_pipe.md
Name: vga_pixel_pipe

Overview:
- Sits between the VGA timing controller and the monitor/DAC outputs; runs entirely on the 25.175 MHz VGA pixel clock.
- Consumes per-pixel x/y coordinates plus the hsync, vsync, sync_b and blank_b strobes from the controller.
- Reads an internal 160x120 RGB332 framebuffer, upscaled 4x to 640x480, and emits registered 8-bit r/g/b with the sync strobes delayed to stay aligned.
- Accepts framebuffer writes from an upstream producer through a valid/ready port that is serviced only during blanking.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- SCALE_LOG2, 2, log2 of the upscale factor, applied to both axes.
- FB_W, H_ACT>>SCALE_LOG2 = 160, framebuffer width.
- FB_H, V_ACT>>SCALE_LOG2 = 120, framebuffer height.
- AW, 15, framebuffer address width (FB_W*FB_H = 19200 < 2^AW).

Ports:
- clk  in  1  VGA pixel clock.
- reset  in  1  synchronous, active-high reset.
- x  in  10  current pixel column from the timing controller.
- y  in  10  current line from the timing controller.
- hsync_i  in  1  horizontal sync from the controller.
- vsync_i  in  1  vertical sync from the controller.
- sync_b_i  in  1  composite sync_b from the controller.
- blank_b_i  in  1  high during active video.
- wr_valid  in  1  write request from the producer.
- wr_addr  in  AW  framebuffer address, row-major: y*FB_W + x.
- wr_data  in  8  RGB332 pixel, r[7:5] g[4:2] b[1:0].
- wr_ready  out  1  write accepted this cycle when high together with wr_valid.
- wr_drop  out  1  one-cycle pulse: the accepted write had an out-of-range address.
- frame_done  out  1  one-cycle pulse when the last active pixel of a frame has left the pipeline.
- hsync  out  1  delayed hsync_i.
- vsync  out  1  delayed vsync_i.
- sync_b  out  1  delayed sync_b_i.
- blank_b  out  1  delayed blank_b_i.
- r, g, b  out  8 each  pixel colour to the video DAC.

Behaviour:
- Single-port synchronous framebuffer RAM: FB_W*FB_H x 8, one-cycle read latency, contents not reset.
- The port is shared between reads and writes; a read and a write never occur in the same cycle.
- Active condition: act = blank_b_i & (x < H_ACT) & (y < V_ACT).
- When act = 1, the RAM performs a read at address (y>>SCALE_LOG2)*FB_W + (x>>SCALE_LOG2), computed at AW width with no overflow.
- Write port:
  - wr_ready = ~act & ~reset (combinational).
  - A write is accepted when wr_valid & wr_ready.
  - If wr_addr < FB_W*FB_H, the RAM is written that cycle.
  - Otherwise the write is discarded and wr_drop = 1 in the following cycle.
  - While wr_ready = 0 the producer holds wr_valid, wr_addr and wr_data stable. No buffering inside this block.
- Pipeline, fixed latency of 2 cycles from inputs to outputs:
  - Stage 1: RAM read data, act_d1, and stage-1 copies of the four strobes.
  - Stage 2: colour expansion and output registers.
  - hsync/vsync/sync_b/blank_b outputs equal their inputs delayed exactly 2 cycles.
- Colour expansion at stage 2, applied when act_d1 = 1:
  - r = {d[7:5], d[7:5], d[7:6]}
  - g = {d[4:2], d[4:2], d[4:3]}
  - b = {d[1:0], d[1:0], d[1:0], d[1:0]}
  - When act_d1 = 0: r = g = b = 0.
- frame_done pulses for one cycle, 2 cycles after the input cycle with x == 0 and y == V_ACT. Exactly one pulse per frame.
- Reset values, held throughout reset:
  - r = g = b = 0; blank_b = 0; hsync = vsync = sync_b = 1.
  - wr_ready = 0, wr_drop = 0, frame_done = 0.
  - All pipeline registers are cleared to the same idle values.
- Reset mid-frame: no write is performed during reset. Outputs show idle values and resume tracking the inputs 2 cycles after reset deasserts. The first 2 post-reset output cycles carry the reset idle values.
- Coordinates beyond the active area (x >= 640 or y >= 480) with blank_b_i = 1 are treated as blank: black output, writes allowed.

Test Plan:
- Reset, then during blanking write wr_addr=0, wr_data=0xE0. Drive x=0..3, y=0..3 with blank_b_i=1 -> r=0xFF, g=0x00, b=0x00 two cycles after each pixel. blank_b output rises exactly 2 cycles after blank_b_i.
- Write wr_addr=161, wr_data=0x6D. Drive x=4..7, y=4..7 active -> r=0x6D, g=0x6D, b=0x55. Neighbouring pixel x=8, y=4 shows the contents of address 162.
- Hold wr_valid=1 across active video -> wr_ready=0 and RAM unchanged throughout. The write completes on the first cycle with blank_b_i=0, and a later read returns the new data.
- Write wr_addr=19200 during blanking -> wr_ready=1, wr_drop=1 the next cycle for exactly one cycle. A full-frame readback matches the prior contents.
- Run 2 full 800x525 frames -> exactly one frame_done pulse per frame, at input cycle (x=0, y=480) + 2. hsync/vsync edges appear exactly 2 cycles after the input edges.
- Assert reset for 3 cycles mid-line with wr_valid=1 -> rgb=0, hsync=vsync=sync_b=1, blank_b=0, wr_ready=0, no RAM write. Outputs track the inputs again 2 cycles after release.
